// File: rtl/mbe_seq_mult_ctrl_if.sv
// Operand, partial-product and result bundle between the MBE sequencer and its environment.
// The environment (operand source, PP generator, result sink) is the master; the sequencer is the slave.
interface mbe_seq_mult_ctrl_if #(
    parameter int INPUT_NBIT   = 24,
    parameter int RES_NBIT     = 27,
    parameter int NUM_PAR_PROD = 9
);
    logic                      in_valid;
    logic                      in_ready;
    logic [INPUT_NBIT-1:0]     X_in;
    logic [INPUT_NBIT-1:0]     Y_in;
    logic [INPUT_NBIT-1:0]     pp_x;
    logic [INPUT_NBIT-1:0]     pp_y;
    logic [RES_NBIT-1:0]       pp0;
    logic [RES_NBIT-1:0]       pp1;
    logic [RES_NBIT-1:0]       pp2;
    logic [RES_NBIT-1:0]       pp3;
    logic [RES_NBIT-1:0]       pp4;
    logic [RES_NBIT-1:0]       pp5;
    logic [RES_NBIT-1:0]       pp6;
    logic [RES_NBIT-1:0]       pp7;
    logic [INPUT_NBIT-1:0]     pp8;
    logic [NUM_PAR_PROD-2:0]   sign_bits;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*INPUT_NBIT-1:0]   product;

    modport master (
        output in_valid, X_in, Y_in,
        output pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, sign_bits,
        output out_ready,
        input  in_ready, pp_x, pp_y, out_valid, product
    );

    modport slave (
        input  in_valid, X_in, Y_in,
        input  pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, sign_bits,
        input  out_ready,
        output in_ready, pp_x, pp_y, out_valid, product
    );
endinterface

// File: rtl/mbe_seq_mult_ctrl.sv
// Sequencer that latches one X*Y pair, then sums one radix-8 MBE partial product per cycle.
// Optional macro MBE_ZERO_SKIP_EN: a zero operand bypasses accumulation and goes straight to DONE.
module mbe_seq_mult_ctrl #(
    parameter int INPUT_NBIT   = 24,
    parameter int RES_NBIT     = 27,
    parameter int NUM_PAR_PROD = 9
) (
    input  logic                clk,
    input  logic                rst,
    mbe_seq_mult_ctrl_if.slave  bus
);
    localparam int ACC_W   = 2 * INPUT_NBIT;
    localparam int NUM_SGN = NUM_PAR_PROD - 1;
    localparam int CNT_W   = $clog2(NUM_PAR_PROD + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAR_PROD - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [INPUT_NBIT-1:0] r_pp_x;
    logic [INPUT_NBIT-1:0] r_pp_y;
    logic                w_accept;
    logic                w_skip;
    logic [ACC_W-1:0]    w_term_sel;

    logic [RES_NBIT-1:0] w_pp   [0:NUM_SGN-1];
    logic [ACC_W-1:0]    w_term [0:NUM_PAR_PROD-1];

    assign w_pp[0] = bus.pp0;
    assign w_pp[1] = bus.pp1;
    assign w_pp[2] = bus.pp2;
    assign w_pp[3] = bus.pp3;
    assign w_pp[4] = bus.pp4;
    assign w_pp[5] = bus.pp5;
    assign w_pp[6] = bus.pp6;
    assign w_pp[7] = bus.pp7;

    // Signed PPs arrive ones'-complemented; sign-extend and add the sign bit to finish the negation.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SGN; gi++) begin : g_term
            logic [ACC_W-1:0] w_ext;
            assign w_ext = {{(ACC_W-RES_NBIT){bus.sign_bits[gi]}}, w_pp[gi]}
                         + {{(ACC_W-1){1'b0}}, bus.sign_bits[gi]};
            assign w_term[gi] = w_ext << (3 * gi);
        end
    endgenerate

    assign w_term[NUM_SGN] = {{(ACC_W-INPUT_NBIT){1'b0}}, bus.pp8} << (3 * NUM_SGN);

    always_comb begin
        w_term_sel = '0;
        for (int k = 0; k < NUM_PAR_PROD; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_term_sel = w_term[k];
            end
        end
    end

`ifdef MBE_ZERO_SKIP_EN
    assign w_skip = (bus.X_in == '0) || (bus.Y_in == '0);
`else
    assign w_skip = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = w_skip ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operands stay frozen from accept to the next accept so the PP generator is stable throughout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_pp_x <= '0;
            r_pp_y <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_pp_x <= bus.X_in;
            r_pp_y <= bus.Y_in;
        end else if (r_state == S_ACC) begin
            r_cnt  <= r_cnt + 1'b1;
            r_acc  <= r_acc + w_term_sel;
        end
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.product   = '0;
        bus.pp_x      = r_pp_x;
        bus.pp_y      = r_pp_y;
        case (r_state)
            S_IDLE: bus.in_ready = 1'b1;
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.product   = r_acc;
            end
            default: ;
        endcase
    end
endmodule
